// File: rtl/vga_layer_compositor.sv
// N-layer priority pixel compositor with per-layer enable, frame blink and colour key.
// HS/VS/rgb leave through a matched 2-stage pipeline so sync stays aligned to pixels.

module vga_layer_qual #(
  parameter logic [7:0] KEY_RGB = 8'h00
) (
  input  logic       active,
  input  logic       en,
  input  logic       blink,
  input  logic       blink_on,
  input  logic       key_en,
  input  logic [7:0] rgb,
  output logic       q
);
  // Hidden, keyed and disabled layers all collapse to q=0 so lower layers show through.
  assign q = active & en & ~(blink & ~blink_on) & ~(key_en & (rgb == KEY_RGB));
endmodule

module vga_layer_compositor #(
  parameter int         LAYERS       = 7,
  parameter logic [7:0] KEY_RGB      = 8'h00,
  parameter int         BLINK_FRAMES = 30,
  parameter logic       SYNC_ACTIVE  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  hs_in,
  input  logic                  vs_in,
  input  logic                  blank_in,
  input  logic [8*LAYERS-1:0]   layer_rgb,
  input  logic [LAYERS-1:0]     layer_active,
  input  logic [LAYERS-1:0]     layer_en,
  input  logic [LAYERS-1:0]     blink_mask,
  input  logic                  key_en,
  input  logic [7:0]            bg_rgb,
  output logic                  HS,
  output logic                  VS,
  output logic [7:0]            rgb,
  output logic [15:0]           frame_cnt,
  output logic                  blink_on
);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [LAYERS-1:0]       q_d, q_s1;
  logic [LAYERS-1:0][7:0]  rgb_s1;
  logic                    blank_s1;
  logic [1:0]              hs_pipe, vs_pipe;
  logic [7:0]              pix;
  logic [BW-1:0]           blink_cnt;
  logic                    frame_edge;

  for (genvar i = 0; i < LAYERS; i++) begin : g_layer
    vga_layer_qual #(.KEY_RGB(KEY_RGB)) u_qual (
      .active   (layer_active[i]),
      .en       (layer_en[i]),
      .blink    (blink_mask[i]),
      .blink_on (blink_on),
      .key_en   (key_en),
      .rgb      (layer_rgb[8*i +: 8]),
      .q        (q_d[i])
    );
  end

  // Stage 1: qualified layer flags, colours, blank, and first sync tap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_s1     <= '0;
      rgb_s1   <= '0;
      blank_s1 <= 1'b0;
    end else begin
      q_s1     <= q_d;
      rgb_s1   <= layer_rgb;
      blank_s1 <= blank_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_pipe <= {2{~SYNC_ACTIVE}};
      vs_pipe <= {2{~SYNC_ACTIVE}};
    end else begin
      hs_pipe <= {hs_pipe[0], hs_in};
      vs_pipe <= {vs_pipe[0], vs_in};
    end
  end

  assign HS = hs_pipe[1];
  assign VS = vs_pipe[1];

  // Stage 2: lowest-index qualified layer wins; bg_rgb is the live input here.
  always_comb begin
    pix = bg_rgb;
    for (int i = LAYERS - 1; i >= 0; i--)
      if (q_s1[i]) pix = rgb_s1[i];
    if (blank_s1) pix = 8'h00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rgb <= 8'h00;
    else          rgb <= pix;
  end

  // Frame edge: stage-1 VS just became active while the stage-2 copy is still inactive.
  assign frame_edge = (vs_pipe[0] == SYNC_ACTIVE) && (vs_pipe[1] != SYNC_ACTIVE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= 16'h0000;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_edge) begin
      frame_cnt <= frame_cnt + 16'd1;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed bench for vga_layer_compositor: priority, key, blank, sync delay, blink, reset, wrap.

module tb_vga_layer_compositor;
  localparam int LAYERS = 3;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                hs_in, vs_in, blank_in, key_en;
  logic [8*LAYERS-1:0] layer_rgb;
  logic [LAYERS-1:0]   layer_active, layer_en, blink_mask;
  logic [7:0]          bg_rgb;
  logic                HS, VS, blink_on;
  logic [7:0]          rgb;
  logic [15:0]         frame_cnt;

  int vectors = 0;
  int miscompares = 0;

  vga_layer_compositor #(
    .LAYERS(LAYERS), .KEY_RGB(8'hE0), .BLINK_FRAMES(2), .SYNC_ACTIVE(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
    .layer_rgb(layer_rgb), .layer_active(layer_active), .layer_en(layer_en),
    .blink_mask(blink_mask), .key_en(key_en), .bg_rgb(bg_rgb),
    .HS(HS), .VS(VS), .rgb(rgb), .frame_cnt(frame_cnt), .blink_on(blink_on)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic vs_pulse();
    vs_in = 1'b0;
    tick(2);
    vs_in = 1'b1;
    tick(3);
  endtask

  task automatic test_reset();
    hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b0; key_en = 1'b0;
    layer_rgb = {8'h1C, 8'hE0, 8'h55}; layer_active = '0; layer_en = '1;
    blink_mask = '0; bg_rgb = 8'h03;
    reset_n = 1'b0;
    tick(1);
    vectors++; if (HS !== 1'b1 || VS !== 1'b1) begin miscompares++; $display("FAIL reset_sync HS=%b VS=%b exp 1 1", HS, VS); end
    vectors++; if (rgb !== 8'h00) begin miscompares++; $display("FAIL reset_rgb got %h exp 00", rgb); end
    vectors++; if (frame_cnt !== 16'h0000 || blink_on !== 1'b1) begin miscompares++; $display("FAIL reset_frame cnt=%h blink=%b exp 0000 1", frame_cnt, blink_on); end
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_priority();
    layer_active = 3'b110; layer_en = 3'b111;
    tick(2);
    vectors++; if (rgb !== 8'hE0) begin miscompares++; $display("FAIL t1_prio got %h exp E0", rgb); end
    layer_active = 3'b100;
    tick(2);
    vectors++; if (rgb !== 8'h1C) begin miscompares++; $display("FAIL t1_low got %h exp 1C", rgb); end
    layer_active = 3'b110; layer_en = 3'b101;
    tick(2);
    vectors++; if (rgb !== 8'h1C) begin miscompares++; $display("FAIL t1_disabled got %h exp 1C", rgb); end
    layer_active = 3'b000; layer_en = 3'b111;
    tick(2);
    vectors++; if (rgb !== 8'h03) begin miscompares++; $display("FAIL t1_bg got %h exp 03", rgb); end
    layer_active = 3'b111;
    tick(2);
    vectors++; if (rgb !== 8'h55) begin miscompares++; $display("FAIL t1_top got %h exp 55", rgb); end
  endtask

  task automatic test_key();
    key_en = 1'b1; layer_active = 3'b110;
    tick(2);
    vectors++; if (rgb !== 8'h1C) begin miscompares++; $display("FAIL t2_key got %h exp 1C", rgb); end
    layer_active = 3'b010;
    tick(2);
    vectors++; if (rgb !== 8'h03) begin miscompares++; $display("FAIL t2_key_bg got %h exp 03", rgb); end
    key_en = 1'b0;
    tick(2);
    vectors++; if (rgb !== 8'hE0) begin miscompares++; $display("FAIL t2_key_off got %h exp E0", rgb); end
  endtask

  task automatic test_blank_sync();
    logic [9:0] hp, vp;
    hp = 10'b0110100110;
    vp = 10'b1100111010;
    layer_rgb = {8'h1C, 8'hE0, 8'hFF}; layer_active = 3'b001; blank_in = 1'b1;
    tick(2);
    vectors++; if (rgb !== 8'h00) begin miscompares++; $display("FAIL t3_blank got %h exp 00", rgb); end
    blank_in = 1'b0;
    tick(2);
    vectors++; if (rgb !== 8'hFF) begin miscompares++; $display("FAIL t3_unblank got %h exp FF", rgb); end
    for (int k = 0; k < 10; k++) begin
      hs_in = hp[k]; vs_in = vp[k];
      tick(1);
      if (k >= 1) begin
        vectors++;
        if (HS !== hp[k-1] || VS !== vp[k-1]) begin
          miscompares++;
          $display("FAIL t3_sync_delay k=%0d HS=%b VS=%b exp %b %b", k, HS, VS, hp[k-1], vp[k-1]);
        end
      end
    end
    hs_in = 1'b1; vs_in = 1'b1;
    tick(3);
  endtask

  task automatic test_blink();
    logic [5:0] exp_blink;
    exp_blink = 6'b110011; // bit n = blink_on after frame edge n (edge 0 = reset)
    do_reset();
    blink_mask = 3'b001; layer_active = 3'b001;
    layer_rgb = {8'h1C, 8'hE0, 8'hFF};
    tick(2);
    vectors++; if (blink_on !== exp_blink[5] || rgb !== 8'hFF) begin miscompares++; $display("FAIL t4_edge0 blink=%b rgb=%h exp %b FF", blink_on, rgb, exp_blink[5]); end
    for (int n = 1; n <= 5; n++) begin
      vs_pulse();
      vectors++;
      if (blink_on !== exp_blink[5-n]) begin
        miscompares++;
        $display("FAIL t4_blink edge=%0d got %b exp %b", n, blink_on, exp_blink[5-n]);
      end
      vectors++;
      if (rgb !== (exp_blink[5-n] ? 8'hFF : 8'h03)) begin
        miscompares++;
        $display("FAIL t4_hide edge=%0d got %h exp %h", n, rgb, exp_blink[5-n] ? 8'hFF : 8'h03);
      end
    end
    vectors++; if (frame_cnt !== 16'd5) begin miscompares++; $display("FAIL t4_frames got %0d exp 5", frame_cnt); end
    blink_mask = 3'b000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) vs_pulse();
    vectors++; if (frame_cnt !== 16'd3 || blink_on !== 1'b0) begin miscompares++; $display("FAIL t5_setup cnt=%0d blink=%b exp 3 0", frame_cnt, blink_on); end
    hs_in = 1'b0; // mid-line, inside a sync pulse
    tick(2);
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (HS !== 1'b1 || VS !== 1'b1 || rgb !== 8'h00) begin miscompares++; $display("FAIL t5_async_out HS=%b VS=%b rgb=%h exp 1 1 00", HS, VS, rgb); end
    vectors++; if (frame_cnt !== 16'd0 || blink_on !== 1'b1) begin miscompares++; $display("FAIL t5_async_state cnt=%0d blink=%b exp 0 1", frame_cnt, blink_on); end
    hs_in = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    vs_pulse();
    vectors++; if (frame_cnt !== 16'd1 || blink_on !== 1'b1) begin miscompares++; $display("FAIL t5_recover1 cnt=%0d blink=%b exp 1 1", frame_cnt, blink_on); end
    vs_pulse();
    vectors++; if (frame_cnt !== 16'd2 || blink_on !== 1'b0) begin miscompares++; $display("FAIL t5_recover2 cnt=%0d blink=%b exp 2 0", frame_cnt, blink_on); end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.frame_cnt = 16'hFFFE;
    tick(1);
    release dut.frame_cnt;
    tick(1);
    vs_pulse();
    vectors++; if (frame_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL t6_ffff got %h exp FFFF", frame_cnt); end
    vs_pulse();
    vectors++; if (frame_cnt !== 16'h0000) begin miscompares++; $display("FAIL t6_wrap got %h exp 0000", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_key();
    test_blank_sync();
    test_blink();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
